// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline-stage buffer: DEPTH-entry FIFO with valid/ready on both sides,
// single-cycle flush, and an all-zero payload (NOP bubble) whenever no entry is live.
module pipe_stage_fifo #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] storage [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;

  // Explicit wrap so non-power-of-two depths cycle through exactly DEPTH slots.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake outputs look only at registered state: no in->out or out_ready->in_ready path.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? storage[rd_ptr] : '0;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      // NOTE: storage is reset deliberately so no stale payload can ever leak
      // through a slot; this costs a reset on every entry instead of a plain RAM.
      for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
    end else begin
      if (push) begin
        storage[wr_ptr] <= in_data;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: a DEPTH=2 and a DEPTH=3 instance checked every cycle
// against queue models, plus directed literal expectations.
module tb_pipe_stage_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        v2 = 1'b0, r2 = 1'b0, f2 = 1'b0;
  logic [63:0] d2 = '0;
  logic        in_ready2, out_valid2;
  logic [63:0] out_data2;
  logic [1:0]  count2;

  logic        v3 = 1'b0, r3 = 1'b0, f3 = 1'b0;
  logic [63:0] d3 = '0;
  logic        in_ready3, out_valid3;
  logic [63:0] out_data3;
  logic [1:0]  count3;

  int errors = 0;
  int checks = 0;

  logic [63:0] q2[$];
  logic [63:0] q3[$];
  logic [63:0] log2[$];
  bit          log_en2 = 1'b0;
  bit          take2, put2, take3, put3;

  always #5 clk = ~clk;

  pipe_stage_fifo #(.DATA_W(64), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(v2), .in_ready(in_ready2), .in_data(d2),
    .out_valid(out_valid2), .out_ready(r2), .out_data(out_data2),
    .flush(f2), .count(count2)
  );

  pipe_stage_fifo #(.DATA_W(64), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset),
    .in_valid(v3), .in_ready(in_ready3), .in_data(d3),
    .out_valid(out_valid3), .out_ready(r3), .out_data(out_data3),
    .flush(f3), .count(count3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue per instance, capacity DEPTH, flush empties it.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q2.delete();
      q3.delete();
    end else begin
      if (f2) q2.delete();
      else begin
        take2 = r2 && q2.size() > 0;
        put2  = v2 && q2.size() < 2;
        if (take2) void'(q2.pop_front());
        if (put2) q2.push_back(d2);
      end
      if (f3) q3.delete();
      else begin
        take3 = r3 && q3.size() > 0;
        put3  = v3 && q3.size() < 3;
        if (take3) void'(q3.pop_front());
        if (put3) q3.push_back(d3);
      end
    end
  end

  // Single compare process: outputs are registered, so mid-low-phase sampling is stable.
  always @(negedge clk) begin
    check("m2_valid", out_valid2, q2.size() > 0);
    check("m2_data", out_data2, (q2.size() > 0) ? q2[0] : 64'd0);
    check("m2_count", count2, q2.size());
    check("m2_ready", in_ready2, q2.size() < 2);
    check("m3_valid", out_valid3, q3.size() > 0);
    check("m3_data", out_data3, (q3.size() > 0) ? q3[0] : 64'd0);
    check("m3_count", count3, q3.size());
    check("m3_ready", in_ready3, q3.size() < 3);
    if (log_en2 && out_valid2 && r2 && !f2) log2.push_back(out_data2);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    int net;
    logic acc3;

    // Reset held low for 3 cycles with in_valid asserted.
    #1 reset = 1'b0;
    v2 = 1'b1; d2 = 64'h99;
    repeat (3) step();
    check("rst_valid", out_valid2, 0);
    check("rst_data", out_data2, 0);
    check("rst_count", count2, 0);
    check("rst_ready", in_ready2, 1);
    reset = 1'b1;

    // Fill with 0xA, 0xB while downstream stalls.
    d2 = 64'hA; step();
    d2 = 64'hB; step();
    v2 = 1'b0;
    check("fill_count", count2, 2);
    check("fill_ready", in_ready2, 0);
    check("fill_data", out_data2, 64'hA);
    r2 = 1'b1;
    repeat (3) step();
    check("drain_count", count2, 0);

    // Streaming 1..16 with both sides held high.
    log2.delete();
    log_en2 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      v2 = 1'b1; d2 = 64'(i); n = 0;
      do begin
        acc = in_ready2;
        step();
        n++;
      end while (!acc && n < 8);
      check("stream_accept", acc, 1);
      check("stream_count_le2", count2 <= 2, 1);
    end
    v2 = 1'b0;
    repeat (3) step();
    log_en2 = 1'b0;
    check("stream_len", log2.size(), 16);
    for (int i = 0; i < 16 && i < log2.size(); i++) check("stream_order", log2[i], 64'(i + 1));

    // Full buffer with a simultaneous pop: the push is refused that edge.
    r2 = 1'b0; v2 = 1'b1;
    d2 = 64'hA; step();
    d2 = 64'hB; step();
    d2 = 64'hC; r2 = 1'b1; step();
    check("fullpop_data", out_data2, 64'hB);
    check("fullpop_count", count2, 1);
    check("fullpop_ready", in_ready2, 1);
    step();
    check("fullpop_c_data", out_data2, 64'hC);
    check("fullpop_c_count", count2, 1);
    v2 = 1'b0;
    repeat (2) step();
    check("fullpop_empty", out_valid2, 0);

    // Flush beats a same-cycle push and pop.
    r2 = 1'b0; v2 = 1'b1;
    d2 = 64'hA; step();
    d2 = 64'hB; step();
    check("preflush_count", count2, 2);
    f2 = 1'b1; d2 = 64'hD; r2 = 1'b1; step();
    f2 = 1'b0; v2 = 1'b0;
    check("flush_count", count2, 0);
    check("flush_valid", out_valid2, 0);
    check("flush_data", out_data2, 0);
    check("flush_ready", in_ready2, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_d", out_valid2, 0);
    end

    // Random traffic on the DEPTH=3 instance.
    net = 0;
    acc3 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!v3 || acc3) begin
        v3 = 1'($urandom_range(0, 1));
        d3 = {$urandom, $urandom};
      end
      r3 = 1'($urandom_range(0, 1));
      acc3 = v3 && in_ready3;
      if (acc3) net++;
      if (r3 && out_valid3) net--;
      step();
      check("rand_net_count", count3, net);
    end
    v3 = 1'b0; r3 = 1'b0;

    // Asynchronous reset between edges with two entries held.
    r2 = 1'b0; v2 = 1'b1;
    d2 = 64'h11; step();
    d2 = 64'h22; step();
    v2 = 1'b0;
    check("prereset_count", count2, 2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_count", count2, 0);
    check("async_valid", out_valid2, 0);
    check("async_data", out_data2, 0);
    check("async_ready", in_ready2, 1);
    step();
    reset = 1'b1;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
